mdu_issue_ctrl: RTL and testbench
=================================

# mdu_issue_ctrl

Sequencing controller for the shared iterative multiply/divide unit (MDU) of the pipelined core. It sits in EX and accepts the `DivEn`/`DivSel` decode of an OP_REG/OP_REG_32 M-extension instruction. It launches the MDU, stalls PC/ID/EX while the operation is in flight, and formats the final result for EX→MEM. RISC-V divide-by-zero and signed-overflow cases are resolved locally without occupying the MDU.

## Interface

- `XLEN`, 64, datapath width

- `clk  in  1  core clock`
- `rst_n  in  1  asynchronous active-low reset`
- `issue_i  in  1  EX holds a valid M-instruction (DivEn=1)`
- `sel_i  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu`
- `word_i  in  1  W variant (opcode OP_REG_32)`
- `src1_i, src2_i  in  XLEN  forwarded rs1/rs2 values`
- `flush_i  in  1  kill EX (redirect/trap)`
- `mem_stall_i  in  1  downstream stall; EX cannot advance`
- `mdu_start_o  out  1  one-cycle launch pulse`
- `mdu_op_o  out  4  {word, sel} latched at accept`
- `mdu_a_o, mdu_b_o  out  XLEN  latched operands`
- `mdu_kill_o  out  1  one-cycle abort of in-flight op`
- `mdu_done_i  in  1  MDU result valid (single-cycle pulse)`
- `mdu_lo_i, mdu_hi_i  in  XLEN  product low/high or quotient/remainder`
- `stall_o  out  1  freeze PC/ID/EX`
- `result_valid_o  out  1  result_o valid for current EX instruction`
- `result_o  out  XLEN  final rd value`

## Operation

- States: IDLE, START, WAIT, DONE.
- IDLE:
  - `issue_i & ~flush_i` latches operands and op.
  - Special case or cache hit → DONE. Otherwise → START.
  - `stall_o` = `issue_i`, combinational.
- START: `mdu_start_o`=1; `mdu_done_i` is ignored; → WAIT.
- WAIT: on `mdu_done_i`, latch `mdu_lo_i`/`mdu_hi_i` and go → DONE.
- START and WAIT: `stall_o`=1.
- DONE:
  - `result_valid_o`=1 and `stall_o`=0.
  - `issue_i` is ignored, because it is the same instruction.
  - → IDLE when `~mem_stall_i`; otherwise hold DONE with the result stable.
- Result select:
  - mul, div, divu → lo.
  - mulh/mulhsu/mulhu, rem, remu → hi.
  - `word_i`: `result_o` = sign-extend of the selected value's bits [31:0].
- Special cases are evaluated on the operand width: 32-bit slices when `word_i`=1, else XLEN.
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed div/rem with dividend = min-negative and divisor = −1: quotient = dividend, remainder = 0.
  - mul ops never take the special path.
- Flush, in any state, goes → IDLE next cycle.
  - `mdu_kill_o`=1 for one cycle if the state was START or WAIT.
  - `result_valid_o` drops. A late `mdu_done_i` is ignored.
  - Flush has priority over accept and over done in the same cycle.
- Reset (async, mid-op included):
  - State → IDLE.
  - `mdu_start_o`, `mdu_kill_o`, `stall_o`, `result_valid_o` = 0.
  - `result_o`, `mdu_op_o`, `mdu_a_o`, `mdu_b_o` = 0.
  - Cache invalid.

## Timing

- Accept at cycle T (IDLE).
- `mdu_start_o` at T+1.
- Earliest `mdu_done_i` at T+2. Done at cycle D gives `result_valid_o` at D+1.
- Special case or cache hit: `result_valid_o` at T+1, with no `mdu_start_o`.
- Back-to-back: leave DONE at cycle X with the next instruction accepted at X+1 (IDLE). Minimum two cycles per op.
- All outputs are registered except `stall_o`.

## Configuration

- `MDU_REUSE_EN` defined:
  - On each MDU div/rem completion, store {op signedness, `word_i`, operands, quotient, remainder}.
  - A later div/rem issue with identical signedness, word flag and operands hits the cache, regardless of div-vs-rem.
  - Flush while in START/WAIT, and reset, invalidate the cache.
  - mul ops neither hit nor update it.
- `MDU_REUSE_EN` undefined: no cache; every non-special op uses the MDU.

## Test plan

- `div` with src1=100, src2=7; MDU done 34 cycles after start.
  - `mdu_start_o` exactly once.
  - `stall_o` high from accept until DONE.
  - `result_o`=14.
- `remw` with src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF.
  - DONE at T+1 with no start.
  - `result_o`=0.
- `divu` with src2=0.
  - `result_o`=0xFFFF_FFFF_FFFF_FFFF at T+1.
  - `rem` with src2=0 and src1=5 returns 5.
- Flush 3 cycles into WAIT.
  - `mdu_kill_o` pulse, then IDLE.
  - A later `mdu_done_i` produces no `result_valid_o`.
  - The next `mul` accepts normally.
- `mulhu` with src1=src2=2^63, and `mem_stall_i` held for 4 cycles at DONE.
  - `result_o`=0x4000_0000_0000_0000 held stable.
  - `issue_i` is not re-accepted.
- `MDU_REUSE_EN`: `div` 100/7 then `rem` 100/7.
  - The second op gives `result_o`=2 at T+1 with no `mdu_start_o`.
  - With the macro undefined, the second op launches the MDU.

Source files
------------

// File: rtl/mdu_issue_ctrl_if.sv
// Handshake bundle for mdu_issue_ctrl: EX-side request, MDU launch/return, and
// the stall/result signals handed back to the pipeline.
interface mdu_issue_ctrl_if #(
    parameter int XLEN = 64
);
    // EX-side request
    logic            issue;
    logic [2:0]      sel;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            mem_stall;
    // MDU side
    logic            mdu_start;
    logic [3:0]      mdu_op;
    logic [XLEN-1:0] mdu_a;
    logic [XLEN-1:0] mdu_b;
    logic            mdu_kill;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_lo;
    logic [XLEN-1:0] mdu_hi;
    // pipeline side
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;

    // environment: EX pipeline plus the MDU itself
    modport master (
        output issue, sel, word, src1, src2, flush, mem_stall,
        output mdu_done, mdu_lo, mdu_hi,
        input  mdu_start, mdu_op, mdu_a, mdu_b, mdu_kill,
        input  stall, result_valid, result
    );

    // the sequencing controller
    modport slave (
        input  issue, sel, word, src1, src2, flush, mem_stall,
        input  mdu_done, mdu_lo, mdu_hi,
        output mdu_start, mdu_op, mdu_a, mdu_b, mdu_kill,
        output stall, result_valid, result
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: EX-stage sequencer for the shared iterative mul/div unit.
// Launches the MDU, stalls PC/ID/EX while it runs, resolves RISC-V divide-by-zero
// and signed-overflow locally, and formats the rd value (W variants sign-extended).
// Optional macro MDU_REUSE_EN: one-entry cache of the last MDU div/rem so that a
// matching div/rem pair (e.g. div then rem of the same operands) skips the MDU.
module mdu_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nx;
    logic            stall_c;
    logic            start_q, kill_q, valid_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, result_q;

    logic            accept, is_div, sgn, dz, ovf, special, hit, in_flight;
    logic [XLEN-1:0] spec_lo, spec_hi, fast_lo, fast_hi;

    // lo carries product-low/quotient, hi carries product-high/remainder
    function automatic logic [XLEN-1:0] fmt(input logic [2:0] sel, input logic word,
                                            input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi);
        logic [XLEN-1:0] v;
        v = (sel == 3'b000 || sel[2:1] == 2'b10) ? lo : hi;
        if (word) v = {{(XLEN-32){v[31]}}, v[31:0]};
        return v;
    endfunction

    assign accept    = (state == IDLE) && bus.issue && !bus.flush;
    assign in_flight = (state == START) || (state == WAIT);
    assign is_div    = bus.sel[2];
    assign sgn       = ~bus.sel[0];

    // Special cases judged on the operand width actually used by the op
    assign dz = bus.word ? (bus.src2[31:0] == 32'd0) : (bus.src2 == '0);
    assign ovf = sgn && (bus.word ? (bus.src1[31:0] == 32'h8000_0000 && bus.src2[31:0] == 32'hFFFF_FFFF)
                                  : (bus.src1 == MIN_NEG && bus.src2 == {XLEN{1'b1}}));
    assign special = is_div && (dz || ovf);
    // dz: q = all ones, r = dividend; overflow: q = dividend, r = 0
    assign spec_lo = dz ? {XLEN{1'b1}} : bus.src1;
    assign spec_hi = dz ? bus.src1 : '0;

`ifdef MDU_REUSE_EN
    logic            c_vld, c_sgn, c_word;
    logic [XLEN-1:0] c_a, c_b, c_lo, c_hi;

    // div and rem share one entry: the MDU produces both halves in one run
    assign hit = c_vld && is_div && (c_sgn == sgn) && (c_word == bus.word) &&
                 (c_a == bus.src1) && (c_b == bus.src2);
    assign fast_lo = special ? spec_lo : c_lo;
    assign fast_hi = special ? spec_hi : c_hi;

    // Capture each real div/rem completion; an aborted or reset op leaves nothing behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld  <= 1'b0;
            c_sgn  <= 1'b0;
            c_word <= 1'b0;
            c_a    <= '0;
            c_b    <= '0;
            c_lo   <= '0;
            c_hi   <= '0;
        end else if (bus.flush && in_flight) begin
            c_vld <= 1'b0;
        end else if (state == WAIT && bus.mdu_done && op_q[2]) begin
            c_vld  <= 1'b1;
            c_sgn  <= ~op_q[0];
            c_word <= op_q[3];
            c_a    <= a_q;
            c_b    <= b_q;
            c_lo   <= bus.mdu_lo;
            c_hi   <= bus.mdu_hi;
        end
    end
`else
    assign hit     = 1'b0;
    assign fast_lo = spec_lo;
    assign fast_hi = spec_hi;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and pipeline stall; flush overrides accept and done
    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        case (state)
            IDLE: begin
                stall_c = bus.issue;
                if (accept) state_nx = (special || hit) ? DONE : START;
            end
            START: begin
                stall_c  = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                stall_c = 1'b1;
                if (bus.mdu_done) state_nx = DONE;
            end
            DONE: begin
                if (!bus.mem_stall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    // Registered outputs: launch/kill pulses, operand latch, formatted result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            start_q <= (state_nx == START);
            valid_q <= (state_nx == DONE);
            kill_q  <= bus.flush && in_flight;
            if (accept) begin
                op_q <= {bus.word, bus.sel};
                a_q  <= bus.src1;
                b_q  <= bus.src2;
                if (special || hit) result_q <= fmt(bus.sel, bus.word, fast_lo, fast_hi);
            end
            if (state == WAIT && bus.mdu_done && !bus.flush)
                result_q <= fmt(op_q[2:0], op_q[3], bus.mdu_lo, bus.mdu_hi);
        end
    end

    assign bus.stall        = stall_c && rst_n;
    assign bus.mdu_start    = start_q;
    assign bus.mdu_kill     = kill_q;
    assign bus.mdu_op       = op_q;
    assign bus.mdu_a        = a_q;
    assign bus.mdu_b        = b_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: table of ops applied through a behavioural MDU,
// results checked through a scoreboard queue, plus hand sequences for flush,
// downstream stall, and mid-operation reset.
module tb_mdu_issue_ctrl;
    localparam int XLEN = 64;
`ifdef MDU_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if #(.XLEN(XLEN)) bus ();
    mdu_issue_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        word;
        logic [63:0] a, b, exp;
        bit          fast;
        int          lat;
    } vec_t;

    int n_tests = 0, n_fail = 0, n_starts = 0, n_kills = 0, mdu_lat = 3;
    logic [63:0] exp_q[$];
    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference arithmetic for the MDU stand-in
    function automatic void mdu_calc(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] lo, output logic [63:0] hi);
        logic [129:0] pa, pb, p;
        logic signed [63:0] sa, sb, q, r;
        logic signed [31:0] sa32, sb32, q32, r32;
        lo = '0; hi = '0;
        if (!op[2]) begin
            pa = (op[1:0] == 2'b11) ? {66'b0, a} : {{66{a[63]}}, a};
            pb = op[1] ? {66'b0, b} : {{66{b[63]}}, b};
            p  = pa * pb;
            lo = p[63:0];
            hi = p[127:64];
        end else if (op[3]) begin
            if (b[31:0] == 32'd0) begin lo = '1; hi = a; end
            else if (!op[0]) begin
                sa32 = a[31:0]; sb32 = b[31:0];
                q32 = sa32 / sb32; r32 = sa32 % sb32;
                lo = {32'b0, q32}; hi = {32'b0, r32};
            end else begin
                lo = {32'b0, a[31:0] / b[31:0]}; hi = {32'b0, a[31:0] % b[31:0]};
            end
        end else begin
            if (b == 64'd0) begin lo = '1; hi = a; end
            else if (!op[0]) begin
                sa = a; sb = b; q = sa / sb; r = sa % sb;
                lo = q; hi = r;
            end else begin
                lo = a / b; hi = a % b;
            end
        end
    endfunction

    // MDU stand-in: answers mdu_lat cycles after the start pulse; ignores kill on purpose
    logic [63:0] m_lo, m_hi;
    always_comb mdu_calc(bus.mdu_op, bus.mdu_a, bus.mdu_b, m_lo, m_hi);
    assign bus.mdu_lo = m_lo;
    assign bus.mdu_hi = m_hi;

    initial begin
        int cnt;
        cnt = 0;
        bus.mdu_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mdu_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.mdu_done = 1'b1;
            end
            if (bus.mdu_start) cnt = mdu_lat;
        end
    end

    // Scoreboard/monitor: counts pulses, checks each new result against the queue
    initial begin
        logic pv;
        logic [63:0] e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mdu_start) n_starts++;
            if (bus.mdu_kill) n_kills++;
            if (bus.result_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_spurious: result_valid with nothing expected, result=%h", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", bus.result, e);
                end
            end
            pv = bus.result_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string n, input logic [2:0] s, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] e, input bit f, input int l);
        vec_t v;
        v.name = n; v.sel = s; v.word = w; v.a = a; v.b = b; v.exp = e; v.fast = f; v.lat = l;
        return v;
    endfunction

    task automatic drive_op(input logic [2:0] s, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.issue = 1'b1; bus.sel = s; bus.word = w; bus.src1 = a; bus.src2 = b;
    endtask

    task automatic run_op(input vec_t v);
        int s0, cyc;
        bit stall_ok;
        s0 = n_starts; mdu_lat = v.lat; stall_ok = 1'b1;
        tick();
        drive_op(v.sel, v.word, v.a, v.b);
        exp_q.push_back(v.exp);
        #1 check({v.name, "_stall_idle"}, bus.stall, 1'b1);
        tick();
        cyc = 0;
        while (!bus.result_valid && cyc < 100) begin
            if (!bus.stall) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        check({v.name, "_latency"}, cyc, v.fast ? 0 : v.lat + 1);
        check({v.name, "_stall_held"}, stall_ok, 1'b1);
        check({v.name, "_stall_done"}, bus.stall, 1'b0);
        check({v.name, "_starts"}, n_starts - s0, v.fast ? 0 : 1);
        bus.issue = 1'b0;
    endtask

    initial begin
        int s0, k0, cyc;
        bit seen;
        bus.issue = 0; bus.sel = 0; bus.word = 0; bus.src1 = 0; bus.src2 = 0;
        bus.flush = 0; bus.mem_stall = 0;

        tbl.push_back(mk("div_100_7",   3'b100, 0, 64'd100, 64'd7, 64'd14, 0, 34));
        tbl.push_back(mk("rem_100_7",   3'b110, 0, 64'd100, 64'd7, 64'd2, REUSE, 5));
        tbl.push_back(mk("remw_ovf",    3'b110, 1, 64'h0000_0000_8000_0000, '1, 64'd0, 1, 3));
        tbl.push_back(mk("divu_z",      3'b101, 0, 64'd123, 64'd0, '1, 1, 3));
        tbl.push_back(mk("rem_z",       3'b110, 0, 64'd5, 64'd0, 64'd5, 1, 3));
        tbl.push_back(mk("div_ovf",     3'b100, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 3));
        tbl.push_back(mk("divuw_z",     3'b101, 1, 64'd9, 64'h1_0000_0000, '1, 1, 3));
        tbl.push_back(mk("divw_ovf",    3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 3));
        tbl.push_back(mk("div_no_ovf",  3'b100, 0, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, 1));
        tbl.push_back(mk("mul",         3'b000, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 0, 2));
        tbl.push_back(mk("mulh",        3'b001, 0, 64'h8000_0000_0000_0000, 64'd2, '1, 0, 3));
        tbl.push_back(mk("mulhsu",      3'b010, 0, 64'hFFFF_FFFF_FFFF_FFFE, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 3));
        tbl.push_back(mk("mulhu",       3'b011, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 4));
        tbl.push_back(mk("divw",        3'b100, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 4));
        tbl.push_back(mk("remuw",       3'b111, 1, 64'hDEAD_BEEF_FFFF_FFFF, 64'd16, 64'd15, 0, 2));
        tbl.push_back(mk("mulw",        3'b000, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2));
        tbl.push_back(mk("remu",        3'b111, 0, '1, 64'd10, 64'd5, 0, 3));
        tbl.push_back(mk("rem_neg",     3'b110, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 0, 2));

        // reset values
        tick(); tick();
        check("rst_start", bus.mdu_start, 1'b0);
        check("rst_kill", bus.mdu_kill, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_valid", bus.result_valid, 1'b0);
        check("rst_result", bus.result, 64'd0);
        check("rst_op", bus.mdu_op, 4'd0);
        check("rst_a", bus.mdu_a, 64'd0);
        check("rst_b", bus.mdu_b, 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) run_op(tbl[i]);

        // flush beats accept in IDLE
        tick();
        s0 = n_starts;
        drive_op(3'b100, 0, 64'd100, 64'd7);
        bus.flush = 1'b1;
        tick();
        check("flush_idle_valid", bus.result_valid, 1'b0);
        check("flush_idle_start", bus.mdu_start, 1'b0);
        check("flush_idle_kill", bus.mdu_kill, 1'b0);
        bus.flush = 1'b0; bus.issue = 1'b0;
        tick();
        check("flush_idle_starts", n_starts - s0, 0);

        // flush three cycles into WAIT; late done must be dropped
        mdu_lat = 34; k0 = n_kills;
        drive_op(3'b100, 0, 64'd100, 64'd7);
        tick();
        check("flushw_start", bus.mdu_start, 1'b1);
        bus.issue = 1'b0;
        tick(); tick(); tick();
        bus.flush = 1'b1;
        tick();
        check("flushw_kill", bus.mdu_kill, 1'b1);
        check("flushw_stall", bus.stall, 1'b0);
        check("flushw_valid", bus.result_valid, 1'b0);
        bus.flush = 1'b0;
        tick();
        check("flushw_kill_pulse", bus.mdu_kill, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.result_valid) seen = 1'b1;
            tick();
        end
        check("flushw_late_done", seen, 1'b0);
        check("flushw_kills", n_kills - k0, 1);
        run_op(mk("mul_after_flush", 3'b000, 0, 64'd7, 64'd6, 64'd42, 0, 3));
        run_op(mk("rem_after_flush", 3'b110, 0, 64'd100, 64'd7, 64'd2, 0, 3));

        // mulhu held in DONE by downstream stall; issue stays high
        mdu_lat = 3; s0 = n_starts;
        tick();
        drive_op(3'b011, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        exp_q.push_back(64'h4000_0000_0000_0000);
        bus.mem_stall = 1'b1;
        tick();
        cyc = 0;
        while (!bus.result_valid && cyc < 100) begin tick(); cyc++; end
        check("hold_latency", cyc, 4);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", bus.result_valid, 1'b1);
            check("hold_result", bus.result, 64'h4000_0000_0000_0000);
            tick();
        end
        check("hold_starts", n_starts - s0, 1);
        bus.mem_stall = 1'b0; bus.issue = 1'b0;
        tick();
        check("hold_release", bus.result_valid, 1'b0);

        // asynchronous reset in the middle of WAIT
        mdu_lat = 34;
        tick();
        drive_op(3'b100, 0, 64'd100, 64'd7);
        tick(); tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", bus.stall, 1'b0);
        check("arst_valid", bus.result_valid, 1'b0);
        check("arst_start", bus.mdu_start, 1'b0);
        check("arst_result", bus.result, 64'd0);
        check("arst_a", bus.mdu_a, 64'd0);
        check("arst_op", bus.mdu_op, 4'd0);
        bus.issue = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.result_valid) seen = 1'b1;
            tick();
        end
        check("arst_late_done", seen, 1'b0);
        run_op(mk("div_after_rst", 3'b100, 0, 64'd100, 64'd7, 64'd14, 0, 2));

        tick(); tick();
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
